// File: rtl/uart_pkg.sv
// Shared types for the UART result-transmit glue.
// Holds the default data width and the FSM state encoding.
package uart_pkg;

    localparam int DBIT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10
    } state_t;

endpackage

// File: rtl/uart_tx_interface_if.sv
// Bundle between rx FIFO / result register, this glue and uart_tx.
// slave: glue side (rx_empty, leds, tx_done_tick in; d_in, tx_start, rd out).
// master: the surrounding UART top (drives the inputs, observes outputs).
interface uart_tx_interface_if #(
    parameter int DBIT = 8
);
    logic                   tx_done_tick;
    logic                   rx_empty;
    logic        [DBIT-1:0] leds;
    logic signed [DBIT-1:0] d_in;
    logic                   tx_start;
    logic                   rd;

    modport slave (
        input  tx_done_tick,
        input  rx_empty,
        input  leds,
        output d_in,
        output tx_start,
        output rd
    );

    modport master (
        output tx_done_tick,
        output rx_empty,
        output leds,
        input  d_in,
        input  tx_start,
        input  rd
    );
endinterface

// File: rtl/uart_tx_interface.sv
// Pops a pending request from the rx FIFO, latches the result byte and
// starts uart_tx; waits for tx_done_tick before taking the next request.
// Ports: clk, reset (async, active-low), bus (uart_tx_interface_if.slave).
module uart_tx_interface
    import uart_pkg::*;
#(
    parameter int DBIT = DBIT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_tx_interface_if.slave      bus
);

    state_t                 state_q, state_d;
    logic signed [DBIT-1:0] d_in_q, d_in_d;
    logic                   rd_q, rd_d;
    logic                   tx_start_q, tx_start_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            d_in_q     <= '0;
            rd_q       <= 1'b0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_in_q     <= d_in_d;
            rd_q       <= rd_d;
            tx_start_q <= tx_start_d;
        end
    end

    // Outputs are computed here but only ever leave through registers,
    // so there is no combinational path from bus inputs to bus outputs.
    always_comb begin
        state_d    = state_q;
        d_in_d     = d_in_q;
        rd_d       = 1'b0;
        tx_start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.rx_empty) begin
                    rd_d    = 1'b1;
                    d_in_d  = $signed(bus.leds);
                    state_d = START;
                end
            end
            START: begin
                tx_start_d = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                // A tick seen while in START is never looked at, so a
                // stale pulse cannot end the new frame early.
                if (bus.tx_done_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.d_in     = d_in_q;
    assign bus.rd       = rd_q;
    assign bus.tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_tx_interface.sv
// Self-checking bench for uart_tx_interface: directed cases then random
// traffic against a transaction-level model built on cycle indices.
module tb_uart_tx_interface;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    uart_tx_interface_if #(.DBIT(8)) bus ();

    uart_tx_interface #(.DBIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Model: a request accepted at edge index `accept` gives rd after that
    // edge, tx_start after the next; completion needs a tick at an edge at
    // least two after acceptance.
    int       k        = 0;
    int       accept   = -100;
    bit       ready    = 1'b1;
    bit [7:0] exp_d    = 8'h00;
    int       n_accept = 0;
    int       n_rd     = 0;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        ready  = 1'b1;
        accept = k - 100;
        exp_d  = 8'h00;
    endtask

    task automatic model_edge(input bit re, input bit [7:0] l, input bit tk);
        k++;
        if (ready && !re) begin
            ready  = 1'b0;
            accept = k;
            exp_d  = l;
            n_accept++;
        end else if (!ready && tk && k >= accept + 2) begin
            ready = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        if (bus.rd === 1'b1) n_rd++;
        chk({tag, ".rd"}, {7'd0, bus.rd}, {7'd0, accept == k});
        chk({tag, ".tx_start"}, {7'd0, bus.tx_start},
            {7'd0, accept == k - 1});
        chk({tag, ".d_in"}, bus.d_in, exp_d);
    endtask

    task automatic step(input string tag, input bit re,
                        input bit [7:0] l, input bit tk);
        bus.rx_empty     = re;
        bus.leds         = l;
        bus.tx_done_tick = tk;
        @(posedge clk);
        model_edge(re, l, tk);
        #1;
        check_all(tag);
    endtask

    initial begin
        bus.rx_empty     = 1'b0;
        bus.leds         = 8'd213;
        bus.tx_done_tick = 1'b0;
        reset            = 1'b0;
        model_reset();

        // 1. reset held with a pending request
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_all("reset");
        end

        // 2. basic send
        reset = 1'b1;
        step("basic_rd", 1'b0, 8'd213, 1'b0);
        chk("basic_signed", 8'($signed(bus.d_in) + 8'sd43), 8'd0);
        step("basic_start", 1'b1, 8'd213, 1'b0);
        step("basic_wait", 1'b1, 8'd213, 1'b0);

        // 3. completion
        step("done_tick", 1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 3; i++) step("done_idle", 1'b1, 8'h66, 1'b0);

        // 4. back-to-back with leds changing after load
        step("b2b_load1", 1'b0, 8'h12, 1'b0);
        step("b2b_start1", 1'b0, 8'h34, 1'b1);
        step("b2b_wait1", 1'b0, 8'h34, 1'b0);
        step("b2b_tick", 1'b0, 8'h34, 1'b1);
        step("b2b_load2", 1'b0, 8'h34, 1'b0);
        step("b2b_start2", 1'b1, 8'h99, 1'b0);
        step("b2b_wait2", 1'b1, 8'h99, 1'b0);
        step("b2b_tick2", 1'b1, 8'h99, 1'b1);

        // 5. spurious ticks while idle
        for (int i = 0; i < 3; i++) step("spurious", 1'b1, 8'hAA, 1'b1);

        // 6. reset abort while waiting
        step("abort_load", 1'b0, 8'h77, 1'b0);
        step("abort_start", 1'b1, 8'h77, 1'b0);
        step("abort_wait", 1'b1, 8'h77, 1'b0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("abort_now");
        @(posedge clk);
        #1;
        check_all("abort_held");
        reset = 1'b1;
        step("fresh_rd", 1'b0, 8'h5C, 1'b0);
        step("fresh_start", 1'b1, 8'h00, 1'b0);
        step("fresh_wait", 1'b1, 8'h00, 1'b0);
        step("fresh_tick", 1'b1, 8'h00, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom % 3) == 0,
                 8'($urandom),
                 ($urandom % 4) == 0);
        end

        chk("rd_pulses", 8'(n_rd), 8'(n_accept));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
